axis_tone_gen: RTL and testbench

AXIS_TONE_GEN -- requirements
Module: axis_tone_gen

---
 rtl/axis_tone_gen.sv | 131 +++++++++++++
 tb/tb_axis_tone_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tone_gen.sv
// axis_tone_gen: multi-tone direct digital synthesizer with an AXI4-Stream
// master output. Each tone owns a phase accumulator; all tones share one sine
// table. The per-tone samples are scaled, summed and saturated into a single
// signed output stream. The whole pipeline freezes while the sink stalls.
module axis_tone_gen #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int TONES            = 2,
  parameter int PHASE_WIDTH      = 32,
  parameter int LUT_ADDR_WIDTH   = 10,
  parameter int AMP_WIDTH        = 16
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic [TONES*PHASE_WIDTH-1:0]   cfg_phase_inc,
  input  logic [TONES*AMP_WIDTH-1:0]     cfg_amp,
  input  logic [TONES-1:0]               cfg_enable,
  input  logic                           cfg_restart,
  output logic [AXIS_TDATA_WIDTH-1:0]    m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [31:0]                    sts_sat_count
);

  localparam int  W      = AXIS_TDATA_WIDTH;
  localparam int  DEPTH  = 1 << LUT_ADDR_WIDTH;
  localparam int  SUM_W  = W + $clog2(TONES) + 1;
  localparam int  PROD_W = W + AMP_WIDTH + 1;
  localparam real PI     = 3.141592653589793;
  localparam real PEAK   = (2.0 ** (W - 1)) - 1.0;

  // Round half away from zero so the table is symmetric about zero.
  function automatic logic signed [W-1:0] sine_entry(input int k);
    real v;
    v = PEAK * $sin((2.0 * PI * k) / DEPTH);
    if (v >= 0.0) return W'($rtoi(v + 0.5));
    else          return W'(-$rtoi(0.5 - v));
  endfunction

  logic signed [W-1:0] sine_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [W-1:0] ENTRY = sine_entry(k);
    assign sine_rom[k] = ENTRY;
  end

  logic                       advance;
  logic [PHASE_WIDTH-1:0]     acc       [TONES];
  logic [LUT_ADDR_WIDTH-1:0]  s1_addr   [TONES];
  logic signed [W-1:0]        s2_lut    [TONES];
  logic signed [W-1:0]        s3_scaled [TONES];
  logic signed [PROD_W-1:0]   prod_c    [TONES];
  logic signed [W-1:0]        scaled_c  [TONES];
  logic                       s1_valid;
  logic                       s2_valid;
  logic                       s3_valid;
  logic signed [SUM_W-1:0]    sum_c;
  logic [W-1:0]               sat_c;
  logic                       clip_c;

  assign advance = !m_axis_tvalid || m_axis_tready;

  // Phase accumulators: restart zeroes them even while the output is stalled.
  always_ff @(posedge aclk) begin
    for (int t = 0; t < TONES; t++) begin
      if (reset || cfg_restart)
        acc[t] <= '0;
      else if (advance)
        acc[t] <= acc[t] + cfg_phase_inc[t*PHASE_WIDTH +: PHASE_WIDTH];
    end
  end

  // Amplitude scaling; the product of a W-bit signed sample and a non-negative
  // (AMP_WIDTH+1)-bit factor, shifted back by AMP_WIDTH, always fits in W bits.
  always_comb begin
    for (int t = 0; t < TONES; t++) begin
      prod_c[t]   = s2_lut[t] * $signed({1'b0, cfg_amp[t*AMP_WIDTH +: AMP_WIDTH]});
      scaled_c[t] = W'(prod_c[t] >>> AMP_WIDTH);
    end
  end

  // Address capture, synchronous table read and scaling stages.
  always_ff @(posedge aclk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      for (int t = 0; t < TONES; t++) begin
        s1_addr[t]   <= '0;
        s2_lut[t]    <= '0;
        s3_scaled[t] <= '0;
      end
    end else if (advance) begin
      s1_valid <= 1'b1;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      for (int t = 0; t < TONES; t++) begin
        s1_addr[t]   <= acc[t][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
        s2_lut[t]    <= sine_rom[s1_addr[t]];
        s3_scaled[t] <= cfg_enable[t] ? scaled_c[t] : '0;
      end
    end
  end

  // Sum in a widened accumulator, then clip to the signed output range.
  always_comb begin
    sum_c  = '0;
    for (int t = 0; t < TONES; t++)
      sum_c = sum_c + SUM_W'(s3_scaled[t]);
    sat_c  = sum_c[W-1:0];
    clip_c = 1'b0;
    if (sum_c[SUM_W-1:W-1] != {(SUM_W-W+1){sum_c[SUM_W-1]}}) begin
      clip_c = 1'b1;
      sat_c  = sum_c[SUM_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Output register, valid flag and sticky saturation counter.
  always_ff @(posedge aclk) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      sts_sat_count <= '0;
    end else if (advance) begin
      m_axis_tdata  <= sat_c;
      m_axis_tvalid <= s3_valid;
      if (clip_c && s3_valid && (sts_sat_count != 32'hFFFF_FFFF))
        sts_sat_count <= sts_sat_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_tone_gen.sv
// Testbench for axis_tone_gen: directed scenarios with literal expectations
// followed by a randomized run, all checked against a sample-level model.
module tb_axis_tone_gen;

  localparam int  TONES = 2;
  localparam real PI    = 3.141592653589793;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] cfg_phase_inc;
  logic [31:0] cfg_amp;
  logic [1:0]  cfg_enable;
  logic        cfg_restart;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] sts_sat_count;

  axis_tone_gen #(
    .AXIS_TDATA_WIDTH(16),
    .TONES(TONES),
    .PHASE_WIDTH(32),
    .LUT_ADDR_WIDTH(10),
    .AMP_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .cfg_phase_inc(cfg_phase_inc),
    .cfg_amp(cfg_amp),
    .cfg_enable(cfg_enable),
    .cfg_restart(cfg_restart),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .sts_sat_count(sts_sat_count)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sine_ref(input int k);
    real v;
    v = 32767.0 * $sin((2.0 * PI * k) / 1024);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic int tone_val(input int unsigned ph, input int unsigned amp, input bit en);
    longint p;
    if (!en) return 0;
    p = longint'(sine_ref(int'(ph >> 22))) * longint'(amp);
    return int'(p >>> 16);
  endfunction

  // Per advancing cycle m the output is built from the phase that was current
  // three advances earlier and the amplitude/enable applied one advance
  // earlier; history rings only need to reach back a few samples.
  int unsigned m_acc    [TONES];
  int unsigned ph_hist  [8][TONES];
  int unsigned amp_hist [8][TONES];
  bit          en_hist  [8][TONES];
  int          m_adv;
  bit          exp_valid;
  int          exp_data;
  int unsigned exp_sat;

  always @(posedge aclk) begin : model
    int s;
    if (reset) begin
      for (int t = 0; t < TONES; t++) m_acc[t] = 0;
      m_adv     = 0;
      exp_valid = 1'b0;
      exp_data  = 0;
      exp_sat   = 0;
    end else begin
      if (!exp_valid || m_axis_tready) begin
        m_adv++;
        for (int t = 0; t < TONES; t++) begin
          ph_hist[m_adv % 8][t]  = m_acc[t];
          amp_hist[m_adv % 8][t] = cfg_amp[t*16 +: 16];
          en_hist[m_adv % 8][t]  = cfg_enable[t];
          m_acc[t] = m_acc[t] + cfg_phase_inc[t*32 +: 32];
        end
        if (m_adv >= 4) begin
          s = 0;
          for (int t = 0; t < TONES; t++)
            s += tone_val(ph_hist[(m_adv-3) % 8][t], amp_hist[(m_adv-1) % 8][t],
                          en_hist[(m_adv-1) % 8][t]);
          exp_valid = 1'b1;
          if (s > 32767 || s < -32768) begin
            exp_data = (s > 0) ? 32767 : -32768;
            if (exp_sat != 32'hFFFF_FFFF) exp_sat++;
          end else begin
            exp_data = s;
          end
        end
      end
      if (cfg_restart)
        for (int t = 0; t < TONES; t++) m_acc[t] = 0;
    end
  end

  always @(negedge aclk) begin
    if (armed) begin
      check("tvalid", m_axis_tvalid, exp_valid);
      if (exp_valid) check("tdata", $signed(m_axis_tdata), exp_data);
      check("sat_count", sts_sat_count, exp_sat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    cfg_phase_inc = {32'd0, 32'h0040_0000};
    cfg_amp       = {16'hFFFF, 16'hFFFF};
    cfg_enable    = 2'b01;
    cfg_restart   = 1'b0;
    m_axis_tready = 1'b1;
    reset         = 1'b1;
    step();
    armed = 1'b1;
    step();
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", $signed(m_axis_tdata), 0);
    check("reset_sat", sts_sat_count, 0);
    reset = 1'b0;

    // single tone, 2^22 increment: latency and first samples
    repeat (3) step();
    check("tvalid_before_4", m_axis_tvalid, 0);
    step();
    check("tvalid_at_4", m_axis_tvalid, 1);
    check("sample0", $signed(m_axis_tdata), 0);
    step();
    check("sample1", $signed(m_axis_tdata), 200);
    step();
    check("sample2", $signed(m_axis_tdata), 401);

    // restart in mid-stream
    cfg_restart = 1'b1;
    step();
    cfg_restart = 1'b0;
    repeat (3) step();
    step();
    check("restart_sample0", $signed(m_axis_tdata), 0);
    step();
    check("restart_sample1", $signed(m_axis_tdata), 200);

    // stall at sample 50 for 10 cycles
    repeat (49) step();
    m_axis_tready = 1'b0;
    repeat (10) step();
    m_axis_tready = 1'b1;
    repeat (30) step();

    // all tones disabled, then re-enabled phase-coherently
    cfg_enable = 2'b00;
    repeat (4) step();
    check("disabled_zero", $signed(m_axis_tdata), 0);
    repeat (5) step();
    cfg_enable = 2'b01;
    repeat (20) step();

    // two tones at quarter-turn steps: clipping on both peaks
    reset = 1'b1;
    cfg_phase_inc = {32'h4000_0000, 32'h4000_0000};
    cfg_enable    = 2'b11;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("quad_sample0", $signed(m_axis_tdata), 0);
    step();
    check("quad_pos_clip", $signed(m_axis_tdata), 32767);
    check("quad_sat1", sts_sat_count, 1);
    step();
    check("quad_sample2", $signed(m_axis_tdata), 0);
    step();
    check("quad_neg_clip", $signed(m_axis_tdata), -32768);
    check("quad_sat2", sts_sat_count, 2);
    cfg_restart = 1'b1;
    step();
    cfg_restart = 1'b0;
    repeat (4) step();
    check("quad_restart0", $signed(m_axis_tdata), 0);
    step();
    check("quad_restart1", $signed(m_axis_tdata), 32767);

    // reset during a stall with a non-zero saturation count
    m_axis_tready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("stall_reset_tvalid", m_axis_tvalid, 0);
    check("stall_reset_tdata", $signed(m_axis_tdata), 0);
    check("stall_reset_sat", sts_sat_count, 0);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    check("post_reset_tvalid_low", m_axis_tvalid, 0);
    step();
    check("post_reset_tvalid_high", m_axis_tvalid, 1);

    // randomized traffic and configuration churn
    for (int i = 0; i < 3000; i++) begin
      m_axis_tready = ($urandom_range(0, 9) < 7);
      cfg_restart   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0)
        for (int t = 0; t < TONES; t++)
          cfg_phase_inc[t*32 +: 32] = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 1 << 24);
      if ($urandom_range(0, 99) == 0)
        for (int t = 0; t < TONES; t++)
          cfg_amp[t*16 +: 16] = 16'($urandom());
      if ($urandom_range(0, 79) == 0)
        cfg_enable = 2'($urandom());
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    cfg_restart = 1'b0;
    m_axis_tready = 1'b1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
